// File: rtl/mill_modif_deframer.sv
// Modified-Miller frame assembler: turns X/Y/Z symbols into LSB-first bytes with
// odd-parity check, reporting short/partial/standard frames, timeouts and overflow.
module mill_modif_deframer #(
    parameter int TIMEOUT_CLKS = 96,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       in_PoR,
    input  logic [1:0] in_sym,
    input  logic       in_sym_stb,
    output logic [7:0] out_byte,
    output logic [3:0] out_nbits,
    output logic       out_par_err,
    output logic       out_byte_stb,
    output logic       out_eof_stb,
    output logic [6:0] out_len,
    output logic       out_err_stb,
    output logic [1:0] out_err_code,
    output logic       out_busy
);

    // Handshake: in_sym is consumed on every clock in_sym_stb is high (no back-pressure);
    // each out_*_stb is a single-cycle pulse and its data fields hold until the next pulse.

    localparam logic [1:0] SYM_X   = 2'b10;
    localparam logic [1:0] SYM_Y   = 2'b00;
    localparam logic [1:0] SYM_Z   = 2'b01;
    localparam logic [1:0] SYM_ILL = 2'b11;

    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    localparam int              WDW     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WDW-1:0]  WD_LIM  = WDW'(TIMEOUT_CLKS - 1);
    localparam logic [6:0]      MAX_LEN = 7'(MAX_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t         state, state_n;
    logic           pend_valid, pend_valid_n;
    logic           pend_bit, pend_bit_n;
    logic [3:0]     cnt, cnt_n;
    logic [7:0]     shreg, shreg_n;
    logic [6:0]     len, len_n;
    logic [WDW-1:0] wdog, wdog_n;

    logic [7:0]     byte_n;
    logic [3:0]     nbits_n;
    logic           par_err_n;
    logic           byte_stb_n;
    logic           eof_stb_n;
    logic [6:0]     len_out_n;
    logic           err_stb_n;
    logic [1:0]     err_code_n;

    always_ff @(posedge clk) begin
        if (!in_PoR) begin
            state        <= IDLE;
            pend_valid   <= 1'b0;
            pend_bit     <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            len          <= '0;
            wdog         <= '0;
            out_byte     <= '0;
            out_nbits    <= '0;
            out_par_err  <= 1'b0;
            out_byte_stb <= 1'b0;
            out_eof_stb  <= 1'b0;
            out_len      <= '0;
            out_err_stb  <= 1'b0;
            out_err_code <= '0;
        end else begin
            state        <= state_n;
            pend_valid   <= pend_valid_n;
            pend_bit     <= pend_bit_n;
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            len          <= len_n;
            wdog         <= wdog_n;
            out_byte     <= byte_n;
            out_nbits    <= nbits_n;
            out_par_err  <= par_err_n;
            out_byte_stb <= byte_stb_n;
            out_eof_stb  <= eof_stb_n;
            out_len      <= len_out_n;
            out_err_stb  <= err_stb_n;
            out_err_code <= err_code_n;
        end
    end

    assign out_busy = (state == DATA);

    always_comb begin
        state_n      = state;
        pend_valid_n = pend_valid;
        pend_bit_n   = pend_bit;
        cnt_n        = cnt;
        shreg_n      = shreg;
        len_n        = len;
        wdog_n       = wdog;
        byte_n       = out_byte;
        nbits_n      = out_nbits;
        par_err_n    = out_par_err;
        byte_stb_n   = 1'b0;
        eof_stb_n    = 1'b0;
        len_out_n    = out_len;
        err_stb_n    = 1'b0;
        err_code_n   = out_err_code;

        case (state)
            IDLE: begin
                wdog_n = '0;
                if (in_sym_stb && in_sym == SYM_Z) begin
                    state_n      = DATA;
                    pend_valid_n = 1'b0;
                    pend_bit_n   = 1'b0;
                    cnt_n        = '0;
                    shreg_n      = '0;
                    len_n        = '0;
                end
            end
            DATA: begin
                if (in_sym_stb) begin
                    wdog_n = '0;
                    // A pending 1 means the previous symbol was X, so Z is illegal there.
                    if (in_sym == SYM_ILL || (in_sym == SYM_Z && pend_valid && pend_bit)) begin
                        err_stb_n  = 1'b1;
                        err_code_n = ERR_ILLEGAL;
                        state_n    = IDLE;
                    end else if (in_sym == SYM_Y && !(pend_valid && pend_bit)) begin
                        eof_stb_n = 1'b1;
                        len_out_n = len;
                        state_n   = IDLE;
                        if (cnt != 4'd0) begin
                            byte_stb_n = 1'b1;
                            byte_n     = shreg;
                            nbits_n    = cnt;
                            par_err_n  = 1'b0;
                            len_out_n  = len + 7'd1;
                        end
                    end else begin
                        pend_valid_n = 1'b1;
                        pend_bit_n   = (in_sym == SYM_X);
                        if (pend_valid) begin
                            if (cnt == 4'd8) begin
                                // Committed bit is the parity bit.
                                if (len == MAX_LEN) begin
                                    err_stb_n  = 1'b1;
                                    err_code_n = ERR_OVERFLOW;
                                    state_n    = IDLE;
                                end else begin
                                    byte_stb_n = 1'b1;
                                    byte_n     = shreg;
                                    nbits_n    = 4'd8;
                                    par_err_n  = ~^{pend_bit, shreg};
                                    len_n      = len + 7'd1;
                                    cnt_n      = '0;
                                    shreg_n    = '0;
                                end
                            end else begin
                                shreg_n[cnt[2:0]] = pend_bit;
                                cnt_n             = cnt + 4'd1;
                            end
                        end
                    end
                end else if (wdog == WD_LIM) begin
                    err_stb_n  = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                    state_n    = IDLE;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mill_modif_deframer.sv
// Directed bench for mill_modif_deframer: REQA, full bytes, illegal symbol, timeout,
// mid-frame reset and overflow (instance built with MAX_BYTES=2).
module tb_mill_modif_deframer;

    localparam logic [1:0] X = 2'b10;
    localparam logic [1:0] Y = 2'b00;
    localparam logic [1:0] Z = 2'b01;

    logic       clk = 1'b0;
    logic       in_PoR;
    logic [1:0] in_sym;
    logic       in_sym_stb;
    logic [7:0] out_byte;
    logic [3:0] out_nbits;
    logic       out_par_err;
    logic       out_byte_stb;
    logic       out_eof_stb;
    logic [6:0] out_len;
    logic       out_err_stb;
    logic [1:0] out_err_code;
    logic       out_busy;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         stb_cyc = 0;
    int         err_cyc = 0;
    int         n_byte, n_eof, n_err, coincide;
    logic [7:0] last_byte;
    logic [3:0] last_nbits;
    logic       last_par;
    logic [6:0] last_len;
    logic [1:0] last_code;
    logic       prev_bit;

    logic [1:0] reqa     [10] = '{Z, Z, X, X, Y, Z, X, Y, Z, Y};
    logic [1:0] byte_ok  [12] = '{Z, X, X, Y, Z, X, Y, Z, X, X, Y, Y};
    logic [1:0] byte_bad [12] = '{Z, X, X, Y, Z, X, Y, Z, X, Y, Z, Y};
    logic [8:0] bits_93p = 9'h193;

    mill_modif_deframer #(.TIMEOUT_CLKS(96), .MAX_BYTES(2)) dut (
        .clk          (clk),
        .in_PoR       (in_PoR),
        .in_sym       (in_sym),
        .in_sym_stb   (in_sym_stb),
        .out_byte     (out_byte),
        .out_nbits    (out_nbits),
        .out_par_err  (out_par_err),
        .out_byte_stb (out_byte_stb),
        .out_eof_stb  (out_eof_stb),
        .out_len      (out_len),
        .out_err_stb  (out_err_stb),
        .out_err_code (out_err_code),
        .out_busy     (out_busy)
    );

    // Clock and reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Event capture for single-cycle strobes
    always @(negedge clk) begin
        if (out_byte_stb) begin
            n_byte     = n_byte + 1;
            last_byte  = out_byte;
            last_nbits = out_nbits;
            last_par   = out_par_err;
        end
        if (out_eof_stb) begin
            n_eof    = n_eof + 1;
            last_len = out_len;
        end
        if (out_err_stb) begin
            n_err     = n_err + 1;
            last_code = out_err_code;
            err_cyc   = cyc;
        end
        if (out_eof_stb && out_byte_stb) coincide = coincide + 1;
    end

    // Driver tasks
    task automatic clear_log();
        n_byte = 0; n_eof = 0; n_err = 0; coincide = 0;
        last_byte = '0; last_nbits = '0; last_par = 1'b0; last_len = '0; last_code = '0;
    endtask

    task automatic send(input logic [1:0] s, input int gap);
        @(negedge clk);
        in_sym     = s;
        in_sym_stb = 1'b1;
        @(negedge clk);
        in_sym_stb = 1'b0;
        stb_cyc    = cyc;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic send_reqa(input int gap);
        foreach (reqa[i]) send(reqa[i], gap);
    endtask

    task automatic send_bit(input logic b);
        send(b ? X : (prev_bit ? Y : Z), 32);
        prev_bit = b;
    endtask

    task automatic check_reqa_result(input string name);
        checks++; if (n_byte !== 1) begin errors++; $display("FAIL %s n_byte got %0d want 1", name, n_byte); end
        checks++; if (last_byte !== 8'h26) begin errors++; $display("FAIL %s byte got %h want 26", name, last_byte); end
        checks++; if (last_nbits !== 4'd7) begin errors++; $display("FAIL %s nbits got %0d want 7", name, last_nbits); end
        checks++; if (last_par !== 1'b0) begin errors++; $display("FAIL %s par got %b want 0", name, last_par); end
        checks++; if (n_eof !== 1 || last_len !== 7'd1) begin errors++; $display("FAIL %s eof n=%0d len=%0d want 1/1", name, n_eof, last_len); end
        checks++; if (coincide !== 1) begin errors++; $display("FAIL %s byte_eof_same_cycle got %0d want 1", name, coincide); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL %s n_err got %0d want 0", name, n_err); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", name, out_busy); end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({out_byte, out_nbits, out_par_err, out_byte_stb, out_eof_stb, out_len,
             out_err_stb, out_err_code, out_busy} !== '0) begin
            errors++;
            $display("FAIL %s outputs byte=%h nbits=%0d par=%b stb=%b%b%b len=%0d code=%0d busy=%b want all 0",
                     name, out_byte, out_nbits, out_par_err, out_byte_stb, out_eof_stb, out_err_stb,
                     out_len, out_err_code, out_busy);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        in_PoR = 1'b0; in_sym = 2'b00; in_sym_stb = 1'b0;
        repeat (3) @(negedge clk);
        in_PoR = 1'b1;
        check_outputs_zero("reset");
    endtask

    task automatic test_reqa();
        clear_log();
        send_reqa(32);
        check_reqa_result("reqa");
    endtask

    task automatic test_full_byte(input logic bad);
        string name;
        name = bad ? "byte_par_err" : "byte_par_ok";
        clear_log();
        for (int i = 0; i < 12; i++) send(bad ? byte_bad[i] : byte_ok[i], 32);
        checks++; if (n_byte !== 1 || last_byte !== 8'h93) begin errors++; $display("FAIL %s byte n=%0d got %h want 1/93", name, n_byte, last_byte); end
        checks++; if (last_nbits !== 4'd8) begin errors++; $display("FAIL %s nbits got %0d want 8", name, last_nbits); end
        checks++; if (last_par !== bad) begin errors++; $display("FAIL %s par got %b want %b", name, last_par, bad); end
        checks++; if (n_eof !== 1 || last_len !== 7'd1) begin errors++; $display("FAIL %s eof n=%0d len=%0d want 1/1", name, n_eof, last_len); end
        checks++; if (coincide !== 0) begin errors++; $display("FAIL %s byte_eof_same_cycle got %0d want 0", name, coincide); end
    endtask

    task automatic test_illegal();
        clear_log();
        send(Z, 32);
        checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL illegal busy_after_sof got %b want 1", out_busy); end
        send(X, 32);
        send(Z, 32);
        checks++; if (n_err !== 1 || last_code !== 2'd1) begin errors++; $display("FAIL illegal err n=%0d code=%0d want 1/1", n_err, last_code); end
        checks++; if (out_busy !== 1'b0 || n_eof !== 0 || n_byte !== 0) begin errors++; $display("FAIL illegal aftermath busy=%b eof=%0d byte=%0d want 0/0/0", out_busy, n_eof, n_byte); end
        clear_log();
        send_reqa(32);
        check_reqa_result("illegal_then_reqa");
    endtask

    task automatic test_timeout();
        clear_log();
        send(Z, 32);
        send(X, 32);
        send(X, 32);
        repeat (80) @(negedge clk);
        checks++; if (n_err !== 1 || last_code !== 2'd2) begin errors++; $display("FAIL timeout err n=%0d code=%0d want 1/2", n_err, last_code); end
        checks++; if (err_cyc - stb_cyc !== 96) begin errors++; $display("FAIL timeout delay got %0d want 96", err_cyc - stb_cyc); end
        checks++; if (out_busy !== 1'b0 || n_eof !== 0 || n_byte !== 0) begin errors++; $display("FAIL timeout aftermath busy=%b eof=%0d byte=%0d want 0/0/0", out_busy, n_eof, n_byte); end
    endtask

    task automatic test_timeout_boundary();
        clear_log();
        send_reqa(96);
        check_reqa_result("strobe_at_limit");
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        send(Z, 32);
        send(X, 32);
        @(negedge clk);
        in_PoR = 1'b0;
        @(negedge clk);
        in_PoR = 1'b1;
        check_outputs_zero("reset_mid_frame");
        repeat (120) @(negedge clk);
        checks++; if (n_byte + n_eof + n_err !== 0) begin errors++; $display("FAIL reset_mid_frame strobes byte=%0d eof=%0d err=%0d want none", n_byte, n_eof, n_err); end
        send_reqa(32);
        check_reqa_result("reset_then_reqa");
    endtask

    task automatic test_overflow();
        clear_log();
        send(Z, 32);
        prev_bit = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 9; i++) send_bit(bits_93p[i]);
        send(Y, 32);
        send(Y, 32);
        checks++; if (n_byte !== 2 || last_byte !== 8'h93) begin errors++; $display("FAIL overflow bytes n=%0d last=%h want 2/93", n_byte, last_byte); end
        checks++; if (n_err !== 1 || last_code !== 2'd3) begin errors++; $display("FAIL overflow err n=%0d code=%0d want 1/3", n_err, last_code); end
        checks++; if (n_eof !== 0 || out_busy !== 1'b0) begin errors++; $display("FAIL overflow eof=%0d busy=%b want 0/0", n_eof, out_busy); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_reqa();
        test_full_byte(1'b0);
        test_full_byte(1'b1);
        test_illegal();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_frame();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
